// File: rtl/adder_pipe_32bit_if.sv
// adder_pipe_32bit_if: operand/result handshake bundle for adder_pipe_32bit.
// Optional carry_out signal exists only when ADDER_CARRY_OUT_EN is defined.
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds valid and data stable until that edge.
interface adder_pipe_32bit_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
`ifdef ADDER_CARRY_OUT_EN
    logic        carry_out;
`endif

    // Producer of operands / consumer of results (testbench or upstream logic)
    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum
`ifdef ADDER_CARRY_OUT_EN
        , input carry_out
`endif
    );

    // The adder pipeline itself
    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum
`ifdef ADDER_CARRY_OUT_EN
        , output carry_out
`endif
    );
endinterface

// File: rtl/adder_pipe_32bit.sv
// adder_pipe_32bit: two-stage pipelined 32-bit unsigned adder.
// Stage 1 adds the low 16 bits and registers the carry; stage 2 adds the
// high 16 bits plus that carry. Sum wraps modulo 2^32.
// Optional feature macro: ADDER_CARRY_OUT_EN adds the registered carry_out
// (bit 32 of a + b), aligned with sum.
// o_dbg_state = {s2_state, s1_state}, each 1 = FULL, 0 = EMPTY.
module adder_pipe_32bit (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_pipe_32bit_if.slave    bus,
    output logic [1:0]           o_dbg_state
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_t;

    stage_state_t r_s1_state;
    stage_state_t r_s2_state;
    stage_state_t w_s1_state_nxt;
    stage_state_t w_s2_state_nxt;

    logic        w_s1_valid;
    logic        w_s2_valid;
    logic        w_s1_adv;
    logic        w_s2_adv;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_out_fire;

    logic [16:0] w_lo_sum;
    logic [15:0] r_s1_lo;
    logic        r_s1_c16;
    logic [15:0] r_s1_a_hi;
    logic [15:0] r_s1_b_hi;

    logic [15:0] r_s2_hi;
    logic [15:0] r_s2_lo;

`ifdef ADDER_CARRY_OUT_EN
    logic [16:0] w_hi_sum;
    logic        r_s2_c32;
`else
    logic [15:0] w_hi_sum;
`endif

    // Advance rules: a stage may take new data when its successor can take its
    // current contents. No skid buffer, so in_ready follows out_ready directly.
    assign w_s1_valid = (r_s1_state == ST_FULL);
    assign w_s2_valid = (r_s2_state == ST_FULL);
    assign w_s2_adv   = !w_s2_valid || bus.out_ready;
    assign w_s1_adv   = w_s1_valid && w_s2_adv;
    assign w_in_ready = !w_s1_valid || w_s2_adv;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_out_fire = w_s2_valid && bus.out_ready;

    // Stage occupancy next-state: fill on load, drain on unload without refill
    always_comb begin
        w_s1_state_nxt = r_s1_state;
        w_s2_state_nxt = r_s2_state;
        case (r_s1_state)
            ST_EMPTY: if (w_accept)               w_s1_state_nxt = ST_FULL;
            ST_FULL:  if (w_s1_adv && !w_accept)  w_s1_state_nxt = ST_EMPTY;
        endcase
        case (r_s2_state)
            ST_EMPTY: if (w_s1_adv)               w_s2_state_nxt = ST_FULL;
            ST_FULL:  if (w_out_fire && !w_s1_adv) w_s2_state_nxt = ST_EMPTY;
        endcase
    end

    // Stage occupancy registers; reset empties the pipe and drops in-flight data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_state <= ST_EMPTY;
            r_s2_state <= ST_EMPTY;
        end else begin
            r_s1_state <= w_s1_state_nxt;
            r_s2_state <= w_s2_state_nxt;
        end
    end

    // Low-half add, carry kept separately for the high half in stage 2
    assign w_lo_sum = {1'b0, bus.a[15:0]} + {1'b0, bus.b[15:0]};

    // Stage 1 data: loads only on accept, otherwise holds
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_lo   <= 16'd0;
            r_s1_c16  <= 1'b0;
            r_s1_a_hi <= 16'd0;
            r_s1_b_hi <= 16'd0;
        end else if (w_accept) begin
            r_s1_lo   <= w_lo_sum[15:0];
            r_s1_c16  <= w_lo_sum[16];
            r_s1_a_hi <= bus.a[31:16];
            r_s1_b_hi <= bus.b[31:16];
        end
    end

    // High-half add; the overflow bit is only formed when it is exported
`ifdef ADDER_CARRY_OUT_EN
    assign w_hi_sum = {1'b0, r_s1_a_hi} + {1'b0, r_s1_b_hi} + {16'd0, r_s1_c16};
`else
    assign w_hi_sum = r_s1_a_hi + r_s1_b_hi + {15'd0, r_s1_c16};
`endif

    // Stage 2 data: loads when stage 1 advances, holds bit-stable under stall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_hi <= 16'd0;
            r_s2_lo <= 16'd0;
        end else if (w_s1_adv) begin
            r_s2_hi <= w_hi_sum[15:0];
            r_s2_lo <= r_s1_lo;
        end
    end

`ifdef ADDER_CARRY_OUT_EN
    // Registered bit 32 travels with the stage 2 sum
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_c32 <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_c32 <= w_hi_sum[16];
        end
    end

    assign bus.carry_out = r_s2_c32;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_s2_valid;
    assign bus.sum       = {r_s2_hi, r_s2_lo};
    assign o_dbg_state   = {r_s2_state, r_s1_state};

endmodule
